fifo_serial_tx: RTL
===================

# fifo_serial_tx

Downstream drain stage for the 16-bit SSRAM FIFO block. It pops one word at a time through the FIFO's read port and transmits it on a single-wire, UART-style line: start bit, 16 data bits MSB first, optional parity bit, stop bit. It has a fixed bit period and keeps a running count of words sent. It shares the FIFO's clock and reset domain.

## Interface
- CLKS_PER_BIT, 4: clock cycles per serial bit; legal range 2..255.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- fifo_data  input  16  FIFO read data; valid the cycle after a pop.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  1  registered pop strobe to the FIFO; one cycle per word.
- tx_en  input  1  permit to start a new frame; sampled only in IDLE.
- tx  output  1  serial line; idles high.
- busy  output  1  high from POP through the last cycle of STOP.
- word_cnt  output  16  frames fully transmitted; wraps 0xFFFF -> 0x0000.

## Operation
- States: IDLE, POP, LOAD, START, DATA, PARITY (macro only), STOP.
- IDLE: if tx_en=1 and fifo_empty=0, go to POP; otherwise stay. tx=1, busy=0.
- POP: fifo_rd_en=1 for exactly this cycle, then go to LOAD.
- LOAD: at the closing edge, latch fifo_data into a 16-bit shift register, clear the bit-period counter and bit index, then go to START.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: tx=shift_reg[15]; shift left every CLKS_PER_BIT cycles; 16 bits, then PARITY or STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. At its last edge, word_cnt increments, and the block returns to IDLE.
- Bit-period counter: 8 bits, counts 0..CLKS_PER_BIT-1. Bit index: 5 bits.
- Reset values: tx=1, fifo_rd_en=0, busy=0, word_cnt=0, state=IDLE, shift register=0.
- Reset mid-frame: tx goes to 1 immediately (asynchronous). A word that was already popped is discarded; it is not re-read and not counted.
- tx_en falling mid-frame: the current frame completes; no further pop.
- fifo_empty changes outside IDLE are ignored. Only one pop is outstanding at a time, so the FIFO's flag has settled before the next IDLE sample.

## Timing
- Edge E0 samples IDLE with tx_en=1 and fifo_empty=0. fifo_rd_en is high during the cycle after E0. tx falls at E2, two edges after E0.
- Frame length, without parity: 18×CLKS_PER_BIT cycles from tx falling to the end of STOP. With the macro: 19×CLKS_PER_BIT.
- Back-to-back frames: minimum 2-cycle idle-high gap between frames (IDLE sample + POP + LOAD overlap). The next tx fall occurs 2 cycles after the STOP end edge, plus 1 if IDLE is entered first; exact requirement: ≤3 cycles of tx=1 between STOP end and the next START.
- All outputs are registered; no combinational path from any input to any output.

## Configuration
- FIFO_SERIAL_TX_PARITY_EN defined: PARITY state is inserted between DATA and STOP.
  - tx = XOR of the 16 data bits (even parity) for CLKS_PER_BIT cycles.
  - Frame length becomes 19 bits.
- Not defined: PARITY state and parity logic are absent; DATA goes directly to STOP.

## Test plan
- Reset: assert rst mid-DATA with CLKS_PER_BIT=4 -> tx=1, busy=0, fifo_rd_en=0, word_cnt=0 in the same cycle; no further pop until rst is released and the IDLE condition holds.
- Single word 0xA5C3, CLKS_PER_BIT=4, no macro:
  - exactly one fifo_rd_en pulse;
  - tx: 4 cycles low, then bits 1010010111000011 at 4 cycles each, then 4 cycles high (72 cycles total);
  - word_cnt=1.
- Parity, macro defined:
  - 0xA5C3 -> parity bit 0;
  - 0x0001 -> parity bit 1;
  - each frame 76 cycles.
- Back-to-back: FIFO holds 0x1234 then 0xFFFF, tx_en=1 -> two frames, gap of 2-3 idle-high cycles, exactly 2 pops, word_cnt=2.
- Flow control: tx_en dropped during the first frame's DATA with 3 words queued -> the first frame completes; no second fifo_rd_en; busy=0 after STOP.
- Wrap and empty: word_cnt preloaded to 0xFFFF by sending 65535 frames (or a forced bench value) -> the next frame gives 0x0000. With fifo_empty=1 and tx_en=1 for 100 cycles -> fifo_rd_en stays 0 and tx stays 1.

Source files
------------

// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx: drains a 16-bit FIFO one word at a time onto a UART-style line (start, 16 data MSB first, [parity], stop).
// Latency: tx falls two edges after IDLE samples tx_en=1 & fifo_empty=0; frame = 18 (19 with parity) x CLKS_PER_BIT cycles.
// Backpressure: a new word is popped only from IDLE with tx_en=1 and FIFO non-empty; one pop in flight, frame always completes.
// Optional even parity bit between data and stop: define FIFO_SERIAL_TX_PARITY_EN.
module fifo_serial_tx #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] fifo_data,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic        tx_en,
  output logic        tx,
  output logic        busy,
  output logic [15:0] word_cnt
);

  // Last value of the bit-period counter before a bit boundary.
  localparam logic [7:0] LAST_CNT  = 8'(CLKS_PER_BIT - 1);
  // Index of the final data bit (bits go out MSB first).
  localparam logic [4:0] LAST_BIT  = 5'd15;

`ifdef FIFO_SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_LOAD, S_START, S_DATA, S_STOP
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  idx_q, idx_d;
  logic [15:0] shift_q, shift_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic        tx_q, tx_d;
  logic        fifo_rd_en_q, fifo_rd_en_d;
  logic        busy_q, busy_d;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  logic        bit_end;

  // A bit period closes on the edge where the counter sits at its last value.
  assign bit_end = (cnt_q == LAST_CNT);

  // State register and all datapath/output flops; reset forces the line high at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      idx_q        <= 5'd0;
      shift_q      <= 16'd0;
      word_cnt_q   <= 16'd0;
      tx_q         <= 1'b1;
      fifo_rd_en_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      word_cnt_q   <= word_cnt_d;
      tx_q         <= tx_d;
      fifo_rd_en_q <= fifo_rd_en_d;
      busy_q       <= busy_d;
`ifdef FIFO_SERIAL_TX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  // Next-state logic: walk the frame one bit period at a time.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (tx_en && !fifo_empty) state_d = S_POP;
      S_POP:   state_d = S_LOAD;
      S_LOAD:  state_d = S_START;
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA: begin
        if (bit_end && (idx_q == LAST_BIT)) begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef FIFO_SERIAL_TX_PARITY_EN
      S_PARITY: if (bit_end) state_d = S_STOP;
`endif
      S_STOP:  if (bit_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: bit-period counter, bit index, shift register and frame counter.
  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    word_cnt_d = word_cnt_q;
`ifdef FIFO_SERIAL_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      S_LOAD: begin
        // FIFO read data is valid now, one cycle after the pop strobe.
        shift_d  = fifo_data;
        cnt_d    = 8'd0;
        idx_d    = 5'd0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
        parity_d = ^fifo_data;
`endif
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d   = 8'd0;
          idx_d   = idx_q + 5'd1;
          shift_d = {shift_q[14:0], 1'b0};
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d      = 8'd0;
          // Only a frame that reaches the end of its stop bit is counted.
          word_cnt_d = word_cnt_q + 16'd1;
        end else begin
          cnt_d      = cnt_q + 8'd1;
        end
      end
      S_START: cnt_d = bit_end ? 8'd0 : cnt_q + 8'd1;
`ifdef FIFO_SERIAL_TX_PARITY_EN
      S_PARITY: cnt_d = bit_end ? 8'd0 : cnt_q + 8'd1;
`endif
      default: ;
    endcase
  end

  // Output decode from the next state so every output leaves a flop in step with the state.
  always_comb begin
    tx_d         = 1'b1;
    fifo_rd_en_d = 1'b0;
    busy_d       = 1'b1;
    case (state_d)
      S_IDLE:   busy_d       = 1'b0;
      S_POP:    fifo_rd_en_d = 1'b1;
      S_START:  tx_d         = 1'b0;
      S_DATA:   tx_d         = shift_d[15];
`ifdef FIFO_SERIAL_TX_PARITY_EN
      S_PARITY: tx_d         = parity_q;
`endif
      default:  ;
    endcase
  end

  assign fifo_rd_en = fifo_rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign word_cnt   = word_cnt_q;

endmodule
